// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp                                                   |
// | Description : Parametrised register file for the multicycle datapath.      |
// |               Two write ports (port 1 has priority on an address clash),   |
// |               two combinational read ports, an optional hard-wired zero    |
// |               register, optional write-to-read bypass, and a per-register  |
// |               busy scoreboard for writes still outstanding.                |
// |                                                                            |
// | Ports       : clk, reset            clock / asynchronous active-high reset |
// |               we0, waddr0, wdata0   write port 0 (ALU writeback)           |
// |               we1, waddr1, wdata1   write port 1 (load writeback, priority)|
// |               raddr1/rdata1         read port A (combinational)            |
// |               raddr2/rdata2         read port B (combinational)            |
// |               busy_set, busy_addr   mark a register as write-outstanding   |
// |               busy1, busy2          busy state of raddr1 / raddr2          |
// |               busy_any              OR of all stored busy bits             |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              busy_any
);

    localparam int c_NUM_REGS = 2 ** ADDR_W;
    localparam bit c_ZERO_EN  = (ZERO_REG != 0);
    localparam bit c_BYP_EN   = (BYPASS != 0);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]     r_regs [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] r_busy;

    // ------------------------------------------------------------------------
    // Qualified write / busy-set enables.
    // Writes and busy-sets aimed at a hard-wired zero register are dropped
    // here so that neither the storage nor the scoreboard ever sees them.
    // Port 0 is also dropped when port 1 targets the same address, so at
    // most one port ever writes a given register in a cycle.
    // ------------------------------------------------------------------------
    logic w_wen0;
    logic w_wen1;
    logic w_bset;

    assign w_wen1 = we1 && !(c_ZERO_EN && (waddr1 == '0));
    assign w_wen0 = we0 && !(c_ZERO_EN && (waddr0 == '0))
                        && !(w_wen1 && (waddr0 == waddr1));
    assign w_bset = busy_set && !(c_ZERO_EN && (busy_addr == '0));

    // ------------------------------------------------------------------------
    // Scoreboard update masks. A completing write clears the bit, a newly
    // issued producer sets it; the set is applied last so that a producer
    // issued in the same cycle as an older one completes keeps the register
    // marked busy.
    // ------------------------------------------------------------------------
    logic [c_NUM_REGS-1:0] w_clr_mask;
    logic [c_NUM_REGS-1:0] w_set_mask;
    logic [c_NUM_REGS-1:0] w_busy_next;

    for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_dec
        assign w_clr_mask[i] = (w_wen0 && (waddr0 == ADDR_W'(i)))
                            || (w_wen1 && (waddr1 == ADDR_W'(i)));
        assign w_set_mask[i] = w_bset && (busy_addr == ADDR_W'(i));
    end

    assign w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;

    // ------------------------------------------------------------------------
    // Storage and scoreboard registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wen0) begin
                r_regs[waddr0] <= wdata0;
            end
            if (w_wen1) begin
                r_regs[waddr1] <= wdata1;
            end
            r_busy <= w_busy_next;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports. Both ports share one structure, indexed 0 (A) and 1 (B).
    // Output is forced to zero while reset is held, even if a write is being
    // presented, so that nothing leaks through the bypass path during reset.
    // A forwarded read also reports not-busy: the value it returns is the one
    // the outstanding producer is delivering right now.
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_rbusy [2];

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic w_hit0;
        logic w_hit1;
        logic w_zero;

        assign w_hit0 = c_BYP_EN && w_wen0 && (waddr0 == w_raddr[p]);
        assign w_hit1 = c_BYP_EN && w_wen1 && (waddr1 == w_raddr[p]);
        assign w_zero = reset || (c_ZERO_EN && (w_raddr[p] == '0));

        // Port 1 forwarding takes precedence, mirroring write priority.
        assign w_rdata[p] = w_zero ? '0     :
                            w_hit1 ? wdata1 :
                            w_hit0 ? wdata0 :
                                     r_regs[w_raddr[p]];

        assign w_rbusy[p] = !w_zero && !w_hit0 && !w_hit1 && r_busy[w_raddr[p]];
    end

    assign rdata1   = w_rdata[0];
    assign rdata2   = w_rdata[1];
    assign busy1    = w_rbusy[0];
    assign busy2    = w_rbusy[1];
    assign busy_any = |r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_mp                                                |
// | Description : Self-checking bench for regfile_mp. Three instances:         |
// |               A = 32x32, zero reg, bypass; B = 32x32, no zero reg, no      |
// |               bypass (shares A's inputs); C = 8x16, zero reg, bypass.      |
// |               Directed table, hand sequences and random stimulus, all      |
// |               checked against an array-based reference model.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Shared inputs for A and B
    logic        we0, we1, busy_set;
    logic [4:0]  waddr0, waddr1, raddr1, raddr2, busy_addr;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
    logic        busy1_a, busy2_a, busy_any_a, busy1_b, busy2_b, busy_any_b;

    // Inputs/outputs for C
    logic        we0_c, we1_c, busy_set_c;
    logic [2:0]  waddr0_c, waddr1_c, raddr1_c, raddr2_c, busy_addr_c;
    logic [15:0] wdata0_c, wdata1_c, rdata1_c, rdata2_c;
    logic        busy1_c, busy2_c, busy_any_c;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_a), .rdata2(rdata2_a),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .busy1(busy1_a), .busy2(busy2_a), .busy_any(busy_any_a)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .busy1(busy1_b), .busy2(busy2_b), .busy_any(busy_any_b)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset),
        .we0(we0_c), .waddr0(waddr0_c), .wdata0(wdata0_c),
        .we1(we1_c), .waddr1(waddr1_c), .wdata1(wdata1_c),
        .raddr1(raddr1_c), .raddr2(raddr2_c), .rdata1(rdata1_c), .rdata2(rdata2_c),
        .busy_set(busy_set_c), .busy_addr(busy_addr_c),
        .busy1(busy1_c), .busy2(busy2_c), .busy_any(busy_any_c)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;

    // ------------------------------------------------------------------------
    // Reference model: plain arrays per configuration (0=A, 1=B, 2=C)
    // ------------------------------------------------------------------------
    logic [31:0] m_reg  [3][32];
    bit          m_busy [3][32];
    bit          cfg_zero [3];
    bit          cfg_byp  [3];
    int          cfg_n    [3];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [phase %0d]: got 0x%0h, expected 0x%0h", name, phase, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
    endtask

    function automatic void get_wr(int k, output bit w0, output int a0, output logic [31:0] d0,
                                   output bit w1, output int a1, output logic [31:0] d1);
        if (k < 2) begin
            w0 = we0; a0 = int'(waddr0); d0 = wdata0;
            w1 = we1; a1 = int'(waddr1); d1 = wdata1;
        end else begin
            w0 = we0_c; a0 = int'(waddr0_c); d0 = {16'h0, wdata0_c};
            w1 = we1_c; a1 = int'(waddr1_c); d1 = {16'h0, wdata1_c};
        end
    endfunction

    function automatic logic [31:0] exp_rd(int k, int ra);
        bit w0, w1; int a0, a1; logic [31:0] d0, d1;
        get_wr(k, w0, a0, d0, w1, a1, d1);
        if (reset) return '0;
        if (cfg_zero[k] && ra == 0) return '0;
        if (cfg_byp[k] && w1 && a1 == ra) return d1;
        if (cfg_byp[k] && w0 && a0 == ra) return d0;
        return m_reg[k][ra];
    endfunction

    function automatic logic [31:0] exp_busy(int k, int ra);
        bit w0, w1; int a0, a1; logic [31:0] d0, d1;
        get_wr(k, w0, a0, d0, w1, a1, d1);
        if (reset) return '0;
        if (cfg_zero[k] && ra == 0) return '0;
        if (cfg_byp[k] && ((w1 && a1 == ra) || (w0 && a0 == ra))) return '0;
        return {31'h0, m_busy[k][ra]};
    endfunction

    function automatic logic [31:0] exp_any(int k);
        for (int i = 0; i < cfg_n[k]; i++)
            if (m_busy[k][i]) return 32'd1;
        return '0;
    endfunction

    // Apply the current cycle's inputs to the model (called just before the edge)
    task automatic commit(int k);
        bit w0, w1, bs; int a0, a1, ba; logic [31:0] d0, d1;
        get_wr(k, w0, a0, d0, w1, a1, d1);
        bs = (k < 2) ? busy_set : busy_set_c;
        ba = (k < 2) ? int'(busy_addr) : int'(busy_addr_c);
        if (reset) return;
        if (w0 && !(cfg_zero[k] && a0 == 0)) begin m_reg[k][a0] = d0; m_busy[k][a0] = 1'b0; end
        if (w1 && !(cfg_zero[k] && a1 == 0)) begin m_reg[k][a1] = d1; m_busy[k][a1] = 1'b0; end
        if (bs && !(cfg_zero[k] && ba == 0)) m_busy[k][ba] = 1'b1;
    endtask

    task automatic check_all();
        chk("a.rdata1",   rdata1_a,          exp_rd(0, int'(raddr1)));
        chk("a.rdata2",   rdata2_a,          exp_rd(0, int'(raddr2)));
        chk("a.busy1",    32'(busy1_a),      exp_busy(0, int'(raddr1)));
        chk("a.busy2",    32'(busy2_a),      exp_busy(0, int'(raddr2)));
        chk("a.busy_any", 32'(busy_any_a),   exp_any(0));
        chk("b.rdata1",   rdata1_b,          exp_rd(1, int'(raddr1)));
        chk("b.rdata2",   rdata2_b,          exp_rd(1, int'(raddr2)));
        chk("b.busy1",    32'(busy1_b),      exp_busy(1, int'(raddr1)));
        chk("b.busy2",    32'(busy2_b),      exp_busy(1, int'(raddr2)));
        chk("b.busy_any", 32'(busy_any_b),   exp_any(1));
        chk("c.rdata1",   {16'h0, rdata1_c}, exp_rd(2, int'(raddr1_c)));
        chk("c.rdata2",   {16'h0, rdata2_c}, exp_rd(2, int'(raddr2_c)));
        chk("c.busy1",    32'(busy1_c),      exp_busy(2, int'(raddr1_c)));
        chk("c.busy2",    32'(busy2_c),      exp_busy(2, int'(raddr2_c)));
        chk("c.busy_any", 32'(busy_any_c),   exp_any(2));
    endtask

    // Called at the negedge: compare everything, update the model, cross the edge
    task automatic finish_cycle();
        check_all();
        for (int k = 0; k < 3; k++) commit(k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; busy_set = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr1 = '0; raddr2 = '0; busy_addr = '0;
        we0_c = 0; we1_c = 0; busy_set_c = 0;
        waddr0_c = '0; waddr1_c = '0; wdata0_c = '0; wdata1_c = '0;
        raddr1_c = '0; raddr2_c = '0; busy_addr_c = '0;
    endtask

    function automatic logic [4:0] rnd_addr5();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    // ------------------------------------------------------------------------
    // Directed table for instance A (expected outputs seen before the edge)
    // ------------------------------------------------------------------------
    typedef struct {
        bit          we0;  int wa0; logic [31:0] wd0;
        bit          we1;  int wa1; logic [31:0] wd1;
        int          ra1;  int ra2;
        bit          bs;   int ba;
        logic [31:0] e_rd1; logic [31:0] e_rd2;
        bit          e_b1;  bit e_any;
    } vec_t;

    function automatic vec_t mkv(bit w0, int a0, logic [31:0] d0, bit w1, int a1, logic [31:0] d1,
                                 int r1, int r2, bit bs, int ba,
                                 logic [31:0] e1, logic [31:0] e2, bit eb1, bit eany);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.ra1 = r1; v.ra2 = r2; v.bs = bs; v.ba = ba;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_b1 = eb1; v.e_any = eany;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        cfg_zero[0] = 1; cfg_byp[0] = 1; cfg_n[0] = 32;
        cfg_zero[1] = 0; cfg_byp[1] = 0; cfg_n[1] = 32;
        cfg_zero[2] = 1; cfg_byp[2] = 1; cfg_n[2] = 8;
        model_clear();
        idle();
        reset = 1'b1;

        //        we0 wa0 wd0           we1 wa1 wd1           ra1 ra2 bs ba  e_rd1         e_rd2         b1 any
        tbl[0]  = mkv(1, 7, 32'h11111111, 1, 7, 32'h22222222, 7,  7,  0, 0,  32'h22222222, 32'h22222222, 0, 0);
        tbl[1]  = mkv(0, 0, 0,            0, 0, 0,            7,  3,  0, 0,  32'h22222222, 32'h0,        0, 0);
        tbl[2]  = mkv(1, 3, 32'hA,        1, 4, 32'hB,        3,  4,  0, 0,  32'hA,        32'hB,        0, 0);
        tbl[3]  = mkv(0, 0, 0,            0, 0, 0,            3,  4,  0, 0,  32'hA,        32'hB,        0, 0);
        tbl[4]  = mkv(1, 0, 32'hFFFFFFFF, 0, 0, 0,            0,  0,  1, 0,  32'h0,        32'h0,        0, 0);
        tbl[5]  = mkv(0, 0, 0,            0, 0, 0,            0,  0,  0, 0,  32'h0,        32'h0,        0, 0);
        tbl[6]  = mkv(0, 0, 0,            1, 9, 32'h1234,     7,  9,  0, 0,  32'h22222222, 32'h1234,     0, 0);
        tbl[7]  = mkv(0, 0, 0,            0, 0, 0,            12, 9,  1, 12, 32'h0,        32'h1234,     0, 0);
        tbl[8]  = mkv(0, 0, 0,            0, 0, 0,            12, 9,  0, 0,  32'h0,        32'h1234,     1, 1);
        tbl[9]  = mkv(1, 12, 32'h55,      0, 0, 0,            12, 9,  0, 0,  32'h55,       32'h1234,     0, 1);
        tbl[10] = mkv(0, 0, 0,            0, 0, 0,            12, 9,  0, 0,  32'h55,       32'h1234,     0, 0);
        tbl[11] = mkv(0, 0, 0,            1, 12, 32'h66,      12, 9,  1, 12, 32'h66,       32'h1234,     0, 0);
        tbl[12] = mkv(0, 0, 0,            0, 0, 0,            12, 9,  0, 0,  32'h66,       32'h1234,     1, 1);
        tbl[13] = mkv(1, 12, 32'h77,      0, 0, 0,            5,  12, 0, 0,  32'h0,        32'h77,       0, 1);
        tbl[14] = mkv(0, 0, 0,            0, 0, 0,            12, 12, 0, 0,  32'h77,       32'h77,       0, 0);

        // ---------------- Phase 1: reset state, every address ----------------
        phase = 1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); raddr1_c = 3'(a);
            @(negedge clk);
            chk("rst.a.rdata1",   rdata1_a, 32'h0);
            chk("rst.a.rdata2",   rdata2_a, 32'h0);
            chk("rst.b.rdata1",   rdata1_b, 32'h0);
            chk("rst.a.busy_any", 32'(busy_any_a), 32'h0);
            chk("rst.c.rdata1",   {16'h0, rdata1_c}, 32'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- Phase 2: directed table ----------------
        phase = 2;
        for (int i = 0; i < 15; i++) begin
            idle();
            we0 = tbl[i].we0; waddr0 = 5'(tbl[i].wa0); wdata0 = tbl[i].wd0;
            we1 = tbl[i].we1; waddr1 = 5'(tbl[i].wa1); wdata1 = tbl[i].wd1;
            raddr1 = 5'(tbl[i].ra1); raddr2 = 5'(tbl[i].ra2);
            busy_set = tbl[i].bs; busy_addr = 5'(tbl[i].ba);
            @(negedge clk);
            chk($sformatf("tbl[%0d].rdata1", i),   rdata1_a,          tbl[i].e_rd1);
            chk($sformatf("tbl[%0d].rdata2", i),   rdata2_a,          tbl[i].e_rd2);
            chk($sformatf("tbl[%0d].busy1", i),    32'(busy1_a),      32'(tbl[i].e_b1));
            chk($sformatf("tbl[%0d].busy_any", i), 32'(busy_any_a),   32'(tbl[i].e_any));
            finish_cycle();
        end

        // ---------------- Phase 3: no-bypass / ordinary reg0 on B ----------------
        phase = 3;
        idle();
        we1 = 1; waddr1 = 5'd9; wdata1 = 32'hABCD; raddr2 = 5'd9; raddr1 = 5'd0;
        @(negedge clk);
        chk("b.nobypass_old",  rdata2_b, 32'h1234);
        chk("a.bypass_new",    rdata2_a, 32'hABCD);
        chk("b.reg0_value",    rdata1_b, 32'hFFFFFFFF);
        chk("b.reg0_busy",     32'(busy1_b), 32'h1);
        chk("a.reg0_zero",     rdata1_a, 32'h0);
        finish_cycle();
        idle(); raddr2 = 5'd9;
        @(negedge clk);
        chk("b.nobypass_new",  rdata2_b, 32'hABCD);
        finish_cycle();

        // ---------------- Phase 4: small config C ----------------
        phase = 4;
        for (int i = 0; i < 8; i += 2) begin
            idle();
            we0_c = 1; waddr0_c = 3'(i);     wdata0_c = 16'(i * 32'h1111);
            we1_c = 1; waddr1_c = 3'(i + 1); wdata1_c = 16'((i + 1) * 32'h1111);
            @(negedge clk);
            finish_cycle();
        end
        for (int i = 0; i < 8; i++) begin
            idle(); raddr1_c = 3'(i); raddr2_c = 3'(7 - i);
            @(negedge clk);
            chk("c.readback1", {16'h0, rdata1_c}, 32'(16'(i * 32'h1111)));
            chk("c.readback2", {16'h0, rdata2_c}, 32'(16'((7 - i) * 32'h1111)));
            finish_cycle();
        end
        for (int j = 1; j < 8; j++) begin
            idle(); busy_set_c = 1; busy_addr_c = 3'(j);
            @(negedge clk);
            chk("c.any_setting", 32'(busy_any_c), (j == 1) ? 32'h0 : 32'h1);
            finish_cycle();
        end
        for (int j = 1; j < 8; j++) begin
            idle(); we0_c = 1; waddr0_c = 3'(j); wdata0_c = 16'(j);
            raddr1_c = 3'(j); raddr2_c = 3'd7;
            @(negedge clk);
            chk("c.any_clearing", 32'(busy_any_c), 32'h1);
            chk("c.busy1_fwd",    32'(busy1_c), 32'h0);
            chk("c.busy2_r7",     32'(busy2_c), (j == 7) ? 32'h0 : 32'h1);
            finish_cycle();
        end
        idle(); busy_set_c = 1; busy_addr_c = 3'd0;
        @(negedge clk);
        chk("c.any_cleared", 32'(busy_any_c), 32'h0);
        finish_cycle();
        idle();
        @(negedge clk);
        chk("c.any_zero_set", 32'(busy_any_c), 32'h0);
        finish_cycle();

        // ---------------- Phase 5: asynchronous reset mid-run ----------------
        phase = 5;
        idle(); we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; busy_set = 1; busy_addr = 5'd6;
        @(negedge clk);
        finish_cycle();
        idle(); raddr1 = 5'd5; raddr2 = 5'd6;
        @(negedge clk);
        chk("pre_reset.rdata1", rdata1_a, 32'hDEADBEEF);
        chk("pre_reset.busy2",  32'(busy2_a), 32'h1);
        #1 reset = 1'b1;
        model_clear();
        #1;
        chk("async_reset.a.rdata1",  rdata1_a, 32'h0);
        chk("async_reset.b.rdata1",  rdata1_b, 32'h0);
        chk("async_reset.busy2",     32'(busy2_a), 32'h0);
        chk("async_reset.busy_any",  32'(busy_any_a), 32'h0);
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'h1; busy_set = 1; busy_addr = 5'd5;
        @(posedge clk); #1;
        chk("in_reset.rdata1",   rdata1_a, 32'h0);
        chk("in_reset.busy_any", 32'(busy_any_a), 32'h0);
        @(negedge clk);
        idle(); raddr1 = 5'd5;
        reset = 1'b0;
        #1;
        chk("post_reset.a.rdata1", rdata1_a, 32'h0);
        chk("post_reset.b.rdata1", rdata1_b, 32'h0);
        chk("post_reset.busy1",    32'(busy1_a), 32'h0);
        @(posedge clk); #1;

        // ---------------- Phase 6: random stimulus vs model ----------------
        phase = 6;
        for (int n = 0; n < 300; n++) begin
            we0 = 1'($urandom_range(0, 1)); waddr0 = rnd_addr5(); wdata0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); waddr1 = rnd_addr5(); wdata1 = $urandom;
            raddr1 = rnd_addr5(); raddr2 = rnd_addr5();
            busy_set = 1'($urandom_range(0, 1)); busy_addr = rnd_addr5();
            we0_c = 1'($urandom_range(0, 1)); waddr0_c = 3'($urandom); wdata0_c = 16'($urandom);
            we1_c = 1'($urandom_range(0, 1)); waddr1_c = 3'($urandom); wdata1_c = 16'($urandom);
            raddr1_c = 3'($urandom); raddr2_c = 3'($urandom);
            busy_set_c = 1'($urandom_range(0, 1)); busy_addr_c = 3'($urandom);
            @(negedge clk);
            finish_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the multicycle datapath.
- Successor to the fixed 32x32 single-write register file:
  - configurable data width and depth
  - two write ports with fixed priority
  - optional hard-wired zero register
  - optional write-to-read bypass
  - per-register busy scoreboard, so control can stall on registers that still have a write outstanding (multicycle loads)
- Sits between the instruction register fields (read/write addresses) and the ALU/memory writeback muxes.

Parameters:
- DATA_W, 32: width of each register and of every data port.
- ADDR_W, 5: address width; depth NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 always reads 0, and writes/busy-sets to it are ignored; 0 = register 0 is ordinary.
- BYPASS, 1: 1 = a read of an address being written in the same cycle returns the new write data; 0 = reads return stored contents only.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- we0, input, 1: write enable, port 0 (ALU writeback).
- waddr0, input, ADDR_W: write address, port 0.
- wdata0, input, DATA_W: write data, port 0.
- we1, input, 1: write enable, port 1 (memory/load writeback); has priority over port 0.
- waddr1, input, ADDR_W: write address, port 1.
- wdata1, input, DATA_W: write data, port 1.
- raddr1, input, ADDR_W: read address A.
- raddr2, input, ADDR_W: read address B.
- rdata1, output, DATA_W: read data A (combinational).
- rdata2, output, DATA_W: read data B (combinational).
- busy_set, input, 1: mark busy_addr as having a write outstanding.
- busy_addr, input, ADDR_W: register to mark busy.
- busy1, output, 1: register at raddr1 is busy (combinational).
- busy2, output, 1: register at raddr2 is busy (combinational).
- busy_any, output, 1: OR of all busy bits.

Behaviour:
- Reset:
  - reset high asserts all registers to 0 and all busy bits to 0 immediately, independent of clk.
  - While reset is high: rdata1/rdata2 = 0, busy1/busy2/busy_any = 0; writes and busy_set are ignored.
  - Deassertion takes effect at the next rising edge; no partial update occurs on that edge if reset is still high.
- Writes:
  - On posedge clk, if weN is set, reg[waddrN] <= wdataN.
  - If we0 and we1 target the same address, port 1 wins; port 0 is dropped.
  - Different addresses: both writes commit in the same cycle.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Reads:
  - Purely combinational, zero-cycle latency.
  - With ZERO_REG=1, address 0 always returns 0, regardless of bypass.
  - With BYPASS=1, a read address matching an enabled write address this cycle returns that write's data; if both ports match, wdata1 is returned.
  - With BYPASS=0, the new value is visible only after the edge.
- Scoreboard (one busy bit per register):
  - Set on posedge when busy_set=1 (ignored for address 0 if ZERO_REG=1).
  - Cleared on posedge when either write port writes that address.
  - Set and clear on the same address in the same cycle: set wins, because a new producer was issued after the completing one.
- busyN output:
  - busyN = busy[raddrN], except it reads 0 when BYPASS=1 and a write to raddrN is enabled this cycle (the value is forwarded).
  - busy_set in the current cycle does not affect busy1/busy2 until the next edge.
- busy_any is combinational from the stored busy bits only.
- Address width is exact and all addresses are valid; there is no out-of-range case.

Test Plan:
1. Reset, then read every address -> all rdata = 0, busy_any = 0. Assert reset mid-run after writing reg5 = 0xDEADBEEF -> rdata for raddr1 = 5 drops to 0 before the next clk edge.
2. Same-cycle dual write: we0 (reg7, 0x11111111) and we1 (reg7, 0x22222222) -> after the edge, reg7 reads 0x22222222. Dual write to reg3/reg4 with 0xA/0xB -> both stored.
3. ZERO_REG=1: write reg0 = 0xFFFFFFFF and busy_set reg0 -> reg0 reads 0, busy1 = 0, busy_any = 0. Repeat with ZERO_REG=0 -> reg0 reads 0xFFFFFFFF.
4. BYPASS=1: we1 to reg9 = 0x1234 with raddr2 = 9 in the same cycle -> rdata2 = 0x1234 before the edge. BYPASS=0 -> rdata2 shows the old value until the edge.
5. Scoreboard: busy_set reg12 -> busy1 = 1 with raddr1 = 12 from the next cycle. we0 to reg12 -> busy clear after the edge. busy_set and we1 to reg12 in the same cycle -> busy stays 1.
6. Parameter sweep DATA_W = 16, ADDR_W = 3: write each of the 8 registers with its index times 0x1111 -> every readback matches. busy_any tracks set/clear across all 8 registers.
